// File: rtl/nexys4_ddr_pkg.sv
// Shared constants and types for the Nexys4-DDR debug-bus top level.
//   - Bus address map (LED CSR, SW CSR, test memory window)
//   - Test memory depth and default UART bit period
//   - UART debug master command bytes
//   - Address decode helper used by the top level
package nexys4_ddr_pkg;

  localparam logic [31:0] CSR_LED_ADDR = 32'h0000_0000;
  localparam logic [31:0] CSR_SW_ADDR  = 32'h0000_0004;
  localparam logic [31:0] TESTMEM_ADDR = 32'h8000_0000;

  localparam int MEM_DEPTH = 256;

  // 100 MHz / 115200 baud
  localparam int UART_BAUD_DIV = 868;

  // Debug master command bytes. Addresses and data travel LSB first.
  //   CMD_WR   : cmd, addr[4], data[4]        -> no reply
  //   CMD_RD   : cmd, addr[4]                 -> data[4]
  //   CMD_HRST : cmd                          -> pulses the bus reset
  localparam logic [7:0] CMD_WR   = 8'h01;
  localparam logic [7:0] CMD_RD   = 8'h02;
  localparam logic [7:0] CMD_HRST = 8'h03;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_MEM  = 2'd1,
    SEL_LED  = 2'd2,
    SEL_SW   = 2'd3
  } sel_t;

  // Any address with bit 31 set lands in the test memory window;
  // the CSRs are exact-match, everything else is unmapped.
  function automatic sel_t addr_decode(input logic [31:0] addr);
    if (addr[31] == TESTMEM_ADDR[31]) return SEL_MEM;
    else if (addr == CSR_LED_ADDR)    return SEL_LED;
    else if (addr == CSR_SW_ADDR)     return SEL_SW;
    else                              return SEL_NONE;
  endfunction

endpackage

// File: rtl/nexys4_ddr_udm.sv
// udm: UART debug master. Receives 8N1 command frames from the host,
// turns them into single 32-bit bus transactions and returns read data
// over the UART. It also issues a bus-only reset on request.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   rx / tx         - serial line from / to host, idle high
//   bus_rst         - reset for bus peripherals (hreset command)
//   req, we, addr, be, wdata - bus request (held until ack)
//   ack, resp, rdata         - bus completion / read data
module udm
  import nexys4_ddr_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  output logic        bus_rst,
  output logic        req,
  output logic        we,
  output logic [31:0] addr,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic        ack,
  input  logic        resp,
  input  logic [31:0] rdata
);

  localparam logic [15:0] DIV_LAST = 16'(BAUD_DIV - 1);
  // First sample lands mid start bit; the 2-flop input sync already
  // consumed part of the half period.
  localparam logic [15:0] DIV_HALF = 16'(BAUD_DIV / 2 - 2);

  localparam logic [2:0] S_CMD  = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_REQ  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;
  localparam logic [2:0] S_TX   = 3'd5;
  localparam logic [2:0] S_HRST = 3'd6;

  // ---------------- receiver ----------------
  logic        rx_s0, rx_s1;
  logic        rx_busy;
  logic [15:0] rx_cnt;
  logic [3:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_valid;
  logic [7:0]  rx_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s0    <= 1'b1;
      rx_s1    <= 1'b1;
      rx_busy  <= 1'b0;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
    end else begin
      rx_s0    <= rx;
      rx_s1    <= rx_s0;
      rx_valid <= 1'b0;
      if (!rx_busy) begin
        if (!rx_s1) begin
          rx_busy <= 1'b1;
          rx_cnt  <= DIV_HALF;
          rx_bit  <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 16'd1;
      end else begin
        rx_cnt <= DIV_LAST;
        if (rx_bit == 4'd0) begin
          // a start bit that is high again at mid-bit was a glitch
          if (rx_s1) rx_busy <= 1'b0;
          else       rx_bit  <= 4'd1;
        end else if (rx_bit == 4'd9) begin
          rx_busy <= 1'b0;
          if (rx_s1) begin
            rx_valid <= 1'b1;
            rx_byte  <= rx_shift;
          end
        end else begin
          rx_shift <= {rx_s1, rx_shift[7:1]};
          rx_bit   <= rx_bit + 4'd1;
        end
      end
    end
  end

  // ---------------- transmitter ----------------
  logic        tx_busy;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_bit;
  logic [9:0]  tx_shift;
  logic        tx_start;

  logic [2:0]  state;
  logic [2:0]  byte_cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  hcnt;

  assign tx_start = (state == S_TX) && !tx_busy && (byte_cnt != 3'd4);
  assign tx       = tx_busy ? tx_shift[0] : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '1;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      tx_cnt   <= DIV_LAST;
      tx_bit   <= '0;
      tx_shift <= {1'b1, data_q[7:0], 1'b0};
    end else if (tx_busy) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - 16'd1;
      end else begin
        tx_cnt <= DIV_LAST;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
        end else begin
          tx_shift <= {1'b1, tx_shift[9:1]};
          tx_bit   <= tx_bit + 4'd1;
        end
      end
    end
  end

  // ---------------- command FSM ----------------
  assign req     = (state == S_REQ);
  assign we      = we_q;
  assign addr    = addr_q;
  assign wdata   = data_q;
  assign be      = 4'hF;
  assign bus_rst = (state == S_HRST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_CMD;
      byte_cnt <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      hcnt     <= '0;
    end else begin
      case (state)
        S_CMD: begin
          if (rx_valid) begin
            byte_cnt <= '0;
            case (rx_byte)
              CMD_WR: begin
                we_q  <= 1'b1;
                state <= S_ADDR;
              end
              CMD_RD: begin
                we_q  <= 1'b0;
                state <= S_ADDR;
              end
              CMD_HRST: begin
                hcnt  <= 4'hF;
                state <= S_HRST;
              end
              default: ;
            endcase
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            addr_q <= {rx_byte, addr_q[31:8]};
            if (byte_cnt == 3'd3) begin
              byte_cnt <= '0;
              state    <= we_q ? S_DATA : S_REQ;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            data_q <= {rx_byte, data_q[31:8]};
            if (byte_cnt == 3'd3) begin
              byte_cnt <= '0;
              state    <= S_REQ;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        S_REQ: begin
          if (ack) state <= we_q ? S_CMD : S_RESP;
        end
        S_RESP: begin
          if (resp) begin
            data_q   <= rdata;
            byte_cnt <= '0;
            state    <= S_TX;
          end
        end
        S_TX: begin
          // one byte per idle transmitter, LSB first; leave once the
          // fourth byte has fully gone out
          if (tx_start) begin
            data_q   <= {8'h00, data_q[31:8]};
            byte_cnt <= byte_cnt + 3'd1;
          end else if (!tx_busy) begin
            state <= S_CMD;
          end
        end
        S_HRST: begin
          if (hcnt == '0) state <= S_CMD;
          else            hcnt  <= hcnt - 4'd1;
        end
        default: state <= S_CMD;
      endcase
    end
  end

endmodule

// File: rtl/nexys4_ddr_top.sv
// nexys4_ddr_top: board top. A UART debug master (udm) drives a 32-bit
// bus holding an LED CSR, a read-only switch CSR and a 1 KB test memory.
// Ports:
//   CLK100MHZ    - 100 MHz clock
//   CPU_RESETN   - reset button, active low, synchronized into srst
//   SW[15:0]     - slide switches (asynchronous)
//   LED[15:0]    - low half of the LED CSR
//   UART_TXD_IN  - serial from host, idle high
//   UART_RXD_OUT - serial to host, idle high, forced high during srst
module nexys4_ddr_top
  import nexys4_ddr_pkg::*;
#(
  parameter string SIM          = "NO",
  parameter int    CLKS_PER_BIT = UART_BAUD_DIV
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [15:0] SW,
  output logic [15:0] LED,
  input  logic        UART_TXD_IN,
  output logic        UART_RXD_OUT
);

  localparam int          STRETCH      = (SIM == "YES") ? 16 : 1024;
  localparam logic [10:0] STRETCH_LAST = 11'(STRETCH - 1);

  // ---------------- reset synchronizer + stretch ----------------
  logic        rst_s0, rst_s1;
  logic [10:0] rst_cnt;
  logic        srst;

  always_ff @(posedge CLK100MHZ) begin
    rst_s0 <= ~CPU_RESETN;
    rst_s1 <= rst_s0;
    if (rst_s1) begin
      rst_cnt <= '0;
      srst    <= 1'b1;
    end else if (rst_cnt == STRETCH_LAST) begin
      srst <= 1'b0;
    end else begin
      rst_cnt <= rst_cnt + 11'd1;
      srst    <= 1'b1;
    end
  end

  // ---------------- debug master ----------------
  // Bus handshake: udm holds req (with we/addr/be/wdata stable) until it
  // sees ack. ack is req itself, so every request completes in its first
  // cycle, except while periph_rst is high, when no ack is given and the
  // request is ignored. A read's data comes back with a one-cycle resp
  // pulse on the cycle after the ack.
  logic        udm_tx;
  logic        udm_bus_rst;
  logic        req, we, ack, resp;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        periph_rst;

  udm #(
    .BAUD_DIV (CLKS_PER_BIT)
  ) udm (
    .clk     (CLK100MHZ),
    .rst     (srst),
    .rx      (UART_TXD_IN),
    .tx      (udm_tx),
    .bus_rst (udm_bus_rst),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .be      (be),
    .wdata   (wdata),
    .ack     (ack),
    .resp    (resp),
    .rdata   (rdata)
  );

  assign UART_RXD_OUT = srst ? 1'b1 : udm_tx;
  assign periph_rst   = srst | udm_bus_rst;
  assign ack          = req & ~periph_rst;

  sel_t       sel;
  logic [7:0] idx;
  assign sel = addr_decode(addr);
  assign idx = addr[9:2];

  // ---------------- test memory (never reset) ----------------
  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] mem_q;

  always_ff @(posedge CLK100MHZ) begin
    if (ack && we && sel == SEL_MEM) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    mem_q <= mem[idx];
  end

  // ---------------- CSRs and read path ----------------
  logic [31:0] led_q;
  logic [15:0] sw_s0, sw_s1;
  logic        resp_q;
  sel_t        rsel_q;
  logic [31:0] csr_q;

  always_ff @(posedge CLK100MHZ) begin
    if (periph_rst) begin
      led_q  <= '0;
      sw_s0  <= '0;
      sw_s1  <= '0;
      resp_q <= 1'b0;
      rsel_q <= SEL_NONE;
      csr_q  <= '0;
    end else begin
      sw_s0  <= SW;
      sw_s1  <= sw_s0;
      resp_q <= ack & ~we;
      if (ack && !we) begin
        rsel_q <= sel;
        case (sel)
          SEL_LED: csr_q <= led_q;
          SEL_SW:  csr_q <= {16'h0000, sw_s1};
          default: csr_q <= '0;
        endcase
      end
      if (ack && we && sel == SEL_LED) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) led_q[8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign resp  = resp_q;
  assign rdata = (rsel_q == SEL_MEM) ? mem_q : csr_q;
  assign LED   = led_q[15:0];

endmodule

// File: tb/tb_nexys4_ddr_top.sv
module tb_nexys4_ddr_top;
  import nexys4_ddr_pkg::*;

  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        CPU_RESETN;
  logic [15:0] SW;
  logic [15:0] LED;
  logic        UART_TXD_IN;
  logic        UART_RXD_OUT;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  nexys4_ddr_top #(
    .SIM          ("YES"),
    .CLKS_PER_BIT (DIV)
  ) dut (
    .CLK100MHZ    (clk),
    .CPU_RESETN   (CPU_RESETN),
    .SW           (SW),
    .LED          (LED),
    .UART_TXD_IN  (UART_TXD_IN),
    .UART_RXD_OUT (UART_RXD_OUT)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, expected summary before 80000 cycles");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic uart_send(input logic [7:0] b);
    UART_TXD_IN = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      UART_TXD_IN = b[i];
      repeat (DIV) @(negedge clk);
    end
    UART_TXD_IN = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic uart_recv(output logic [7:0] b, output logic ok);
    int n;
    n  = 0;
    b  = '0;
    ok = 1'b0;
    while (UART_RXD_OUT !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n < 4000) begin
      repeat (DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = UART_RXD_OUT;
      end
      repeat (DIV) @(negedge clk);
      ok = (UART_RXD_OUT === 1'b1);
    end
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d);
    uart_send(CMD_WR);
    for (int i = 0; i < 4; i++) uart_send(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) uart_send(d[8*i +: 8]);
    repeat (8) @(negedge clk);
  endtask

  task automatic rd32(input logic [31:0] a, output logic [31:0] d, output logic ok);
    logic [7:0] b;
    logic       okb;
    ok = 1'b1;
    d  = '0;
    fork
      begin
        uart_send(CMD_RD);
        for (int i = 0; i < 4; i++) uart_send(a[8*i +: 8]);
      end
      begin
        for (int j = 0; j < 4; j++) begin
          uart_recv(b, okb);
          d[8*j +: 8] = b;
          ok = ok & okb;
        end
      end
    join
  endtask

  // read and compare against the head of the expected queue
  task automatic rd_check(input string tag, input logic [31:0] a);
    logic [31:0] d;
    logic [31:0] e;
    logic        ok;
    rd32(a, d, ok);
    check({tag, "_frame"}, {31'b0, ok}, 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_expq_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, d, e);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] words [16];
  int          n;

  initial begin
    words = '{32'h112233cc, 32'h0a0b0c0d, 32'h13579bdf, 32'h2468ace0,
              32'h55aa55aa, 32'haa55aa55, 32'h0f0f0f0f, 32'hf0f0f0f0,
              32'h01234567, 32'hdeadbeef, 32'h89abcdef, 32'hcafef00d,
              32'hfedcba98, 32'h00000001, 32'h80000000, 32'hbadc0ffe};
    CPU_RESETN  = 1'b0;
    SW          = 16'h0000;
    UART_TXD_IN = 1'b1;

    // reset: hold 3 cycles, then release and time the stretch
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_srst_high", {31'b0, dut.srst}, 32'd1);
    check("rst_led", {16'h0, LED}, 32'h0);
    check("rst_uart_idle", {31'b0, UART_RXD_OUT}, 32'd1);
    CPU_RESETN = 1'b1;
    n = 0;
    while (dut.srst === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rst_release_within_20", {31'b0, n <= 20}, 32'd1);
    check("rst_release_after_16", {31'b0, n >= 16}, 32'd1);
    check("rst_led_after", {16'h0, LED}, 32'h0);
    check("rst_uart_idle_after", {31'b0, UART_RXD_OUT}, 32'd1);
    repeat (10) @(negedge clk);

    // test memory: 16 words then read back
    for (int i = 0; i < 16; i++) begin
      wr32(32'h80000000 + 32'(4 * i), words[i]);
      exp_q.push_back(words[i]);
    end
    for (int i = 0; i < 16; i++) begin
      rd_check($sformatf("mem_rd%0d", i), 32'h80000000 + 32'(4 * i));
    end

    // LED CSR
    wr32(CSR_LED_ADDR, 32'h5a5a5a5a);
    check("led_out", {16'h0, LED}, 32'h00005a5a);
    exp_q.push_back(32'h5a5a5a5a);
    rd_check("led_rd", 32'h00000000);

    // SW CSR, including an ignored write
    SW = 16'h0030;
    repeat (5) @(negedge clk);
    exp_q.push_back(32'h00000030);
    rd_check("sw_rd30", 32'h00000004);
    SW = 16'h0031;
    repeat (5) @(negedge clk);
    exp_q.push_back(32'h00000031);
    rd_check("sw_rd31", 32'h00000004);
    wr32(32'h00000004, 32'hffffffff);
    exp_q.push_back(32'h00000031);
    rd_check("sw_wr_ignored", 32'h00000004);

    // bus reset via udm: LED cleared, memory kept, udm still alive
    check("led_before_hrst", {16'h0, LED}, 32'h00005a5a);
    uart_send(CMD_HRST);
    repeat (40) @(negedge clk);
    check("led_after_hrst", {16'h0, LED}, 32'h0);
    check("srst_after_hrst", {31'b0, dut.srst}, 32'd0);
    exp_q.push_back(32'hdeadbeef);
    rd_check("mem_after_hrst", 32'h80000024);
    exp_q.push_back(32'h00000000);
    rd_check("led_reg_after_hrst", 32'h00000000);

    // unmapped accesses and memory wrap
    exp_q.push_back(32'h00000000);
    rd_check("unmapped_rd", 32'h00000100);
    wr32(32'h00000008, 32'h12345678);
    exp_q.push_back(32'h00000000);
    rd_check("unmapped_wr_dropped", 32'h00000008);
    check("led_after_unmapped", {16'h0, LED}, 32'h0);
    wr32(32'h80000400, 32'h00000001);
    exp_q.push_back(32'h00000001);
    rd_check("mem_wrap", 32'h80000000);
    exp_q.push_back(32'h0a0b0c0d);
    rd_check("mem_wrap_neighbour", 32'h80000004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nexys4_ddr_top.md
NEXYS4_DDR_TOP -- requirements
Module: nexys4_ddr_top

Interface
REQ-001 Parameter SIM, default "NO"; "YES" selects the short reset stretch for simulation.
REQ-002 One clock CLK100MHZ; reset is synchronous and active-high, as internal signal srst derived from CPU_RESETN.
REQ-003 CLK100MHZ  input  1  100 MHz system clock; all flops on its rising edge.
REQ-004 CPU_RESETN  input  1  board reset button, low when pressed; inverted and synchronized into srst.
REQ-005 SW  input  16  slide switches, asynchronous.
REQ-006 LED  output  16  LED drive.
REQ-007 UART_TXD_IN  input  1  serial data from host (host TX), idle high.
REQ-008 UART_RXD_OUT  output  1  serial data to host, idle high.

Function
REQ-009 srst asserts while CPU_RESETN=0 and stays asserted for 16 cycles (SIM="YES") or 1024 cycles (otherwise) after release, via a 2-flop synchronizer plus counter.
REQ-010 Instance "udm" (UART debug master) runs 8N1 at 115200 baud (868 clocks/bit) and acts as the only 32-bit bus master.
REQ-011 Bus signals: req, we, addr[31:0], be[3:0], wdata[31:0] from udm; ack, resp, rdata[31:0] to udm.
REQ-012 ack = req combinationally, so no wait states; for reads, resp pulses 1 cycle after the accepted req, with rdata valid in that cycle.
REQ-013 Bus reset: periph_rst = srst OR udm reset output; the udm hreset command drives this reset.
REQ-014 Address decode: addr[31]=1 selects test memory; 0x00000000 selects the LED CSR; 0x00000004 selects the SW CSR; all other addresses are unmapped.
REQ-015 Test memory is 1 KB (256x32), indexed by addr[9:2], with upper bits ignored so accesses wrap every 1 KB.
REQ-016 Test memory write: each byte lane is written when its be bit is 1; contents are not cleared by any reset.
REQ-017 LED CSR: a 32-bit register, reset value 0; byte-enabled writes; a read returns the full register; LED = register[15:0].
REQ-018 SW CSR is read-only: rdata = {16'h0, SW synchronized through 2 flops}; writes to it are ignored.
REQ-019 Unmapped accesses are acked; writes are dropped and reads return 0x00000000.
REQ-020 A read and a write never occur in the same cycle, because udm issues one request at a time; requests that arrive while periph_rst is asserted are ignored with no ack.
REQ-021 Reset mid-transaction: a pending resp is cancelled, and the LED register and sync flops return to their reset values.
REQ-022 UART_RXD_OUT = 1 while srst is asserted.

Reset
REQ-023 During srst: LED=0x0000, the LED register is 0, the resp pipeline is cleared, udm is idle, and the SW synchronizer is 0.
REQ-024 udm hreset resets bus peripherals only; it does not reset udm itself or srst.

Structure
REQ-025 A shared package nexys4_ddr_pkg holds the address constants (CSR_LED_ADDR=0x00000000, CSR_SW_ADDR=0x00000004, TESTMEM_ADDR=0x80000000), the memory depth (256), and the baud divider (868).
REQ-026 One sub-module: the existing udm, instantiated as "udm". Reset synchronizer, decode, CSRs and memory are inline in nexys4_ddr_top (about 200 lines).

Verification
REQ-027 Scenario: hold CPU_RESETN=0 for 3 cycles, then release with SIM="YES" -> srst deasserts within 20 cycles and LED=0x0000.
REQ-028 Scenario: wr32 of 0x80000000..0x8000003C with the 16 words 0x112233cc..0xbadc0ffe, then rd32 of each -> identical data returned.
REQ-029 Scenario: wr32(0x00000000, 0x5a5a5a5a) -> LED=0x5a5a; rd32(0x00000000) -> 0x5a5a5a5a.
REQ-030 Scenario: SW=0x0030, then rd32(0x00000004) -> 0x00000030; SW changes to 0x0031 -> the next read returns 0x00000031.
REQ-031 Scenario: udm hreset after the LED write -> LED=0x0000, and rd32(0x80000024) still returns 0xdeadbeef.
REQ-032 Scenario: rd32(0x00000100) -> 0x00000000 with no bus hang; wr32(0x80000400, 0x1) -> reads back from 0x80000000 (wrap).
